signed_bin_to_bcd_seq: RTL and testbench



---
 rtl/signed_bin_to_bcd_seq_pkg.sv | 14 +
 rtl/signed_bin_to_bcd_seq_digit_adj.sv | 12 +
 rtl/signed_bin_to_bcd_seq.sv | 97 +++++++++
 tb/tb_signed_bin_to_bcd_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/signed_bin_to_bcd_seq_pkg.sv
// rtl/signed_bin_to_bcd_seq_pkg.sv - shared types and constants for the signed binary to BCD converter
package signed_bin_to_bcd_seq_pkg;

  localparam int DEF_WIDTH  = 25;
  localparam int DEF_DIGITS = 8;
  localparam int BCD_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/signed_bin_to_bcd_seq_digit_adj.sv
// rtl/signed_bin_to_bcd_seq_digit_adj.sv - single BCD digit "if >= 5 add 3" correction
module bcd_digit_adj
  import signed_bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  // A digit of 5..9 would exceed 9 after doubling, so pre-bias it by 3.
  assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/signed_bin_to_bcd_seq.sv
// rtl/signed_bin_to_bcd_seq.sv - sequential signed two's-complement to sign-plus-BCD converter
module signed_bin_to_bcd_seq
  import signed_bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    sign,
  output logic [BCD_W*DIGITS-1:0] bcd_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = BCD_W * DIGITS;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_L = CNT_W'(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag;
  logic               neg;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic [WIDTH-1:0]   mag_neg;

  // Two's-complement magnitude; the most-negative input maps to 2^(WIDTH-1) unsigned.
  assign mag_neg = ~data_in + ONE;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc[i*BCD_W +: BCD_W]),
      .adj   (acc_adj[i*BCD_W +: BCD_W])
    );
  end

  // Corrected accumulator shifted left with the magnitude MSB entering bit 0.
  assign acc_shift = {acc_adj[ACC_W-2:0], mag[WIDTH-1]};

  // Control FSM; results are published only on the final shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mag     <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sign    <= 1'b0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            neg   <= data_in[WIDTH-1];
            mag   <= data_in[WIDTH-1] ? mag_neg : data_in;
            acc   <= '0;
            cnt   <= CNT_L;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_shift;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt - CNT_1;
          if (cnt == CNT_1) begin
            bcd_out <= acc_shift;
            sign    <= neg;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_bin_to_bcd_seq.sv
// tb/tb_signed_bin_to_bcd_seq.sv - scoreboard bench for the signed binary to BCD converter
module tb_signed_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [24:0] data_in;
  logic        busy;
  logic        done;
  logic        sign;
  logic [31:0] bcd_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic        s;
    logic [31:0] b;
    int          t;
  } exp_t;

  exp_t q[$];

  signed_bin_to_bcd_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .sign    (sign),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done with bcd %h, expected no done (cycle %0d)", bcd_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_sign", {63'd0, sign}, {63'd0, e.s});
        chk("done_bcd", {32'd0, bcd_out}, {32'd0, e.b});
        chk("done_latency", 64'(cyc), 64'(e.t));
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  task automatic push_exp(input logic s, input logic [31:0] b);
    exp_t e;
    e.s = s;
    e.b = b;
    e.t = cyc + 26;
    q.push_back(e);
  endtask

  task automatic do_conv(input logic [24:0] v, input logic s, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    data_in = v;
    push_exp(s, b);
    @(posedge clk);
    #1;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    start   = 1'b0;
    data_in = 25'h0155555;
    repeat (27) @(negedge clk);
  endtask

  initial begin
    int c0;
    int acc_edge [3];
    logic [24:0] b2b_v [3];
    logic        b2b_s [3];
    logic [31:0] b2b_b [3];
    int k;

    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_sign", {63'd0, sign}, 64'd0);
    chk("reset_bcd", {32'd0, bcd_out}, 64'd0);
    rst_n = 1'b1;

    do_conv(25'd0,        1'b0, 32'h00000000);
    do_conv(25'd12345,    1'b0, 32'h00012345);
    do_conv(25'd16777215, 1'b0, 32'h16777215);
    do_conv(25'h1FFFFFF,  1'b1, 32'h00000001);
    do_conv(25'h1000000,  1'b1, 32'h16777216);

    // Start while busy must be ignored.
    @(negedge clk);
    c0      = cyc;
    start   = 1'b1;
    data_in = 25'd999;
    push_exp(1'b0, 32'h00000999);
    @(negedge clk);
    start   = 1'b0;
    chk("sign_holds_while_busy", {63'd0, sign}, 64'd1);
    while (cyc < c0 + 10) @(negedge clk);
    start   = 1'b1;
    data_in = 25'd5;
    @(negedge clk);
    start   = 1'b0;
    repeat (22) @(negedge clk);

    // Reset in the middle of a conversion.
    @(negedge clk);
    c0      = cyc;
    start   = 1'b1;
    data_in = 25'd87654321 % 25'd16777216;
    @(negedge clk);
    start   = 1'b0;
    while (cyc < c0 + 12) @(negedge clk);
    chk("busy_mid_conv", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sign", {63'd0, sign}, 64'd0);
    chk("abort_bcd", {32'd0, bcd_out}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_conv(25'h1FFFF85, 1'b1, 32'h00000123);

    // Back-to-back with start held high; data_in is junk except before each accepting edge.
    b2b_v[0] = 25'd1000000;  b2b_s[0] = 1'b0; b2b_b[0] = 32'h01000000;
    b2b_v[1] = 25'h1FFFC18;  b2b_s[1] = 1'b1; b2b_b[1] = 32'h00001000;
    b2b_v[2] = 25'd9;        b2b_s[2] = 1'b0; b2b_b[2] = 32'h00000009;
    @(negedge clk);
    c0 = cyc;
    for (int i = 0; i < 3; i++) acc_edge[i] = c0 + 1 + 27 * i;
    start = 1'b1;
    k = 0;
    while (cyc < c0 + 81) begin
      if (k < 3 && cyc + 1 == acc_edge[k]) begin
        data_in = b2b_v[k];
        push_exp(b2b_s[k], b2b_b[k]);
        k++;
      end else begin
        data_in = 25'(cyc * 13 + 7);
      end
      @(negedge clk);
    end
    start = 1'b0;

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
